// File: rtl/latch_bank_writer.sv
// Setup/strobe/hold writer for a transparent-latch bank: d settles 1 cycle before c, c is PULSE cycles, rfd low >= PULSE+3.
// rfd deasserts per word until dav_ returns high; optional readback check under LATCH_BANK_WRITER_READBACK_EN.
module latch_bank_writer #(
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 8,
  parameter int PULSE  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dav_,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WIDTH-1:0]     data,
  output logic                 rfd,
  output logic [WIDTH-1:0]     d,
  output logic [2**ADDR_W-1:0] c
`ifdef LATCH_BANK_WRITER_READBACK_EN
  ,
  output logic [ADDR_W-1:0]    rb_sel,
  input  logic [WIDTH-1:0]     rb_q,
  output logic                 err
`endif
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [ADDR_W-1:0]      a_r;
  logic [WIDTH-1:0]       d_r;
  logic                   load;
  logic                   rfd_nxt;
  logic [2**ADDR_W-1:0]   c_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!dav_) begin
          load      = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == PULSE_LAST) state_nxt = HOLD;
        else                   cnt_nxt   = 4'(cnt + 4'd1);
      end
      HOLD:    state_nxt = WAIT;
      WAIT:    if (dav_) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Enables and rfd are decoded from the next state so both leave a flop cleanly.
    c_nxt = '0;
    if (state_nxt == STROBE) c_nxt[a_r] = 1'b1;
    rfd_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      d_r   <= '0;
      c     <= '0;
      rfd   <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      c     <= c_nxt;
      rfd   <= rfd_nxt;
      if (load) begin
        a_r <= addr;
        d_r <= data;
      end
    end
  end

  assign d = d_r;

`ifdef LATCH_BANK_WRITER_READBACK_EN
  assign rb_sel = a_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              err <= 1'b0;
    else if (state == HOLD && rb_q != d_r)  err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench: two writers (PULSE=1 and PULSE=3) each driving a behavioural latch bank.
module tb_latch_bank_writer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       dav1_ = 1'b1, dav3_ = 1'b1;
  logic [1:0] addr1 = '0, addr3 = '0;
  logic [7:0] data1 = '0, data3 = '0;
  logic       rfd1, rfd3;
  logic [7:0] d1, d3;
  logic [3:0] c1, c3;
`ifdef LATCH_BANK_WRITER_READBACK_EN
  logic [1:0] rb_sel1, rb_sel3;
  logic [7:0] rb_q1, rb_q3;
  logic       err1, err3;
`endif

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  bit mon_en   = 1'b0;

  latch_bank_writer #(.ADDR_W(2), .WIDTH(8), .PULSE(1)) u1 (
    .clock(clock), .reset(reset), .dav_(dav1_), .addr(addr1), .data(data1),
    .rfd(rfd1), .d(d1), .c(c1)
`ifdef LATCH_BANK_WRITER_READBACK_EN
    , .rb_sel(rb_sel1), .rb_q(rb_q1), .err(err1)
`endif
  );

  latch_bank_writer #(.ADDR_W(2), .WIDTH(8), .PULSE(3)) u3 (
    .clock(clock), .reset(reset), .dav_(dav3_), .addr(addr3), .data(data3),
    .rfd(rfd3), .d(d3), .c(c3)
`ifdef LATCH_BANK_WRITER_READBACK_EN
    , .rb_sel(rb_sel3), .rb_q(rb_q3), .err(err3)
`endif
  );

  // Transparent latch banks; with readback enabled, bit 0 of bank1 register 1 is stuck at 0.
  logic [7:0] bank1 [4] = '{default: 8'h00};
  logic [7:0] bank3 [4] = '{default: 8'h00};

  always @(c1 or d1) begin
    for (int i = 0; i < 4; i++) begin
      if (c1[i]) begin
        bank1[i] = d1;
`ifdef LATCH_BANK_WRITER_READBACK_EN
        if (i == 1) bank1[i][0] = 1'b0;
`endif
      end
    end
  end

  always @(c3 or d3) begin
    for (int i = 0; i < 4; i++)
      if (c3[i]) bank3[i] = d3;
  end

`ifdef LATCH_BANK_WRITER_READBACK_EN
  assign rb_q1 = bank1[rb_sel1];
  assign rb_q3 = bank3[rb_sel3];
`endif

  // Bus-discipline monitor: d never moves with c or while c is high; c at most one-hot.
  logic [7:0] pd1 = '0, pd3 = '0;
  logic [3:0] pc1 = '0, pc3 = '0;
  always @(negedge clock) begin
    int v;
    v = 0;
    if (mon_en) begin
      if (c1 !== pc1 && d1 !== pd1) v++;
      if (pc1 != 4'b0 && d1 !== pd1) v++;
      if ($countones(c1) > 1) v++;
      if (c3 !== pc3 && d3 !== pd3) v++;
      if (pc3 != 4'b0 && d3 !== pd3) v++;
      if ($countones(c3) > 1) v++;
    end
    viol <= viol + v;
    pd1 <= d1; pc1 <= c1;
    pd3 <= d3; pc3 <= c3;
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (rfd1 !== 1'b1) begin failures++; $display("FAIL reset_rfd1 cyc%0d got=%b want=1", i, rfd1); end
      checks++; if (c1 !== 4'b0)   begin failures++; $display("FAIL reset_c1 cyc%0d got=%b want=0000", i, c1); end
      checks++; if (d1 !== 8'h00)  begin failures++; $display("FAIL reset_d1 cyc%0d got=%h want=00", i, d1); end
      checks++; if (rfd3 !== 1'b1) begin failures++; $display("FAIL reset_rfd3 cyc%0d got=%b want=1", i, rfd3); end
      checks++; if (c3 !== 4'b0)   begin failures++; $display("FAIL reset_c3 cyc%0d got=%b want=0000", i, c3); end
`ifdef LATCH_BANK_WRITER_READBACK_EN
      checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL reset_err1 cyc%0d got=%b want=0", i, err1); end
`endif
    end
    #1 mon_en = 1'b1;
  endtask

  task automatic test_pulse1;
    logic [3:0] exp_c [5];
    logic       exp_r [5];
    exp_c = '{4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clock);
    dav1_ = 1'b0; addr1 = 2'd2; data1 = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) dav1_ = 1'b1;
      checks++; if (rfd1 !== exp_r[i]) begin failures++; $display("FAIL p1_rfd cyc%0d got=%b want=%b", i, rfd1, exp_r[i]); end
      checks++; if (c1 !== exp_c[i])   begin failures++; $display("FAIL p1_c cyc%0d got=%b want=%b", i, c1, exp_c[i]); end
      checks++; if (d1 !== 8'hA5)      begin failures++; $display("FAIL p1_d cyc%0d got=%h want=a5", i, d1); end
    end
    checks++; if (bank1[2] !== 8'hA5) begin failures++; $display("FAIL p1_bank got=%h want=a5", bank1[2]); end
  endtask

  task automatic test_hold_dav;
    int pulses = 0, width = 0, rfd_hi = 0;
    logic [3:0] prev = 4'b0;
    @(negedge clock);
    dav3_ = 1'b0; addr3 = 2'd1; data3 = 8'h5A;
    repeat (20) begin
      @(negedge clock);
      if (c3 != 4'b0 && prev == 4'b0) pulses++;
      if (c3[1]) width++;
      if (rfd3) rfd_hi++;
      prev = c3;
    end
    dav3_ = 1'b1;
    checks++; if (pulses != 1) begin failures++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
    checks++; if (width != 3)  begin failures++; $display("FAIL hold_width got=%0d want=3", width); end
    checks++; if (rfd_hi != 0) begin failures++; $display("FAIL hold_rfd_high got=%0d cycles want=0", rfd_hi); end
    @(negedge clock);
    checks++; if (rfd3 !== 1'b1) begin failures++; $display("FAIL hold_rfd_release got=%b want=1", rfd3); end
    checks++; if (bank3[1] !== 8'h5A) begin failures++; $display("FAIL hold_bank got=%h want=5a", bank3[1]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      int hits = 0, bad = 0;
      @(negedge clock);
      dav1_ = 1'b0; addr1 = 2'(i); data1 = vals[i];
      @(negedge clock);
      dav1_ = 1'b1;
      for (int t = 0; t < 20 && rfd1 !== 1'b1; t++) begin
        @(negedge clock);
        if (c1 != 4'b0) begin
          hits++;
          if (c1 !== (4'b0001 << i) || d1 !== vals[i]) bad++;
        end
      end
      checks++; if (rfd1 !== 1'b1) begin failures++; $display("FAIL b2b_timeout w%0d rfd=%b want=1", i, rfd1); end
      checks++; if (hits != 1) begin failures++; $display("FAIL b2b_hits w%0d got=%0d want=1", i, hits); end
      checks++; if (bad != 0)  begin failures++; $display("FAIL b2b_pulse w%0d bad_cycles=%0d want=0", i, bad); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bank1[i] !== vals[i]) begin failures++; $display("FAIL b2b_bank r%0d got=%h want=%h", i, bank1[i], vals[i]); end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    dav3_ = 1'b0; addr3 = 2'd3; data3 = 8'h77;
    @(negedge clock);
    dav3_ = 1'b1;
    @(negedge clock);
    checks++; if (c3 !== 4'b1000) begin failures++; $display("FAIL mid_strobe got=%b want=1000", c3); end
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++; if (c3 !== 4'b0)   begin failures++; $display("FAIL mid_c_clear got=%b want=0000", c3); end
    checks++; if (rfd3 !== 1'b1) begin failures++; $display("FAIL mid_rfd got=%b want=1", rfd3); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (rfd3 !== 1'b1 || c3 !== 4'b0) begin failures++; $display("FAIL mid_idle rfd=%b c=%b want 1/0000", rfd3, c3); end
    #1 mon_en = 1'b1;
    @(negedge clock);
    dav3_ = 1'b0; addr3 = 2'd2; data3 = 8'h3C;
    @(negedge clock);
    dav3_ = 1'b1;
    for (int t = 0; t < 20 && rfd3 !== 1'b1; t++) @(negedge clock);
    checks++; if (rfd3 !== 1'b1) begin failures++; $display("FAIL mid_next_timeout rfd=%b want=1", rfd3); end
    checks++; if (bank3[2] !== 8'h3C) begin failures++; $display("FAIL mid_next_bank got=%h want=3c", bank3[2]); end
  endtask

`ifdef LATCH_BANK_WRITER_READBACK_EN
  task automatic test_readback;
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL rb_err_pre got=%b want=0", err1); end
    @(negedge clock);
    dav1_ = 1'b0; addr1 = 2'd1; data1 = 8'h01;
    @(negedge clock);
    dav1_ = 1'b1;
    for (int t = 0; t < 20 && rfd1 !== 1'b1; t++) @(negedge clock);
    checks++; if (bank1[1] !== 8'h00) begin failures++; $display("FAIL rb_stuck_bank got=%h want=00", bank1[1]); end
    checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL rb_err_set got=%b want=1", err1); end
    @(negedge clock);
    dav1_ = 1'b0; addr1 = 2'd1; data1 = 8'h02;
    @(negedge clock);
    dav1_ = 1'b1;
    for (int t = 0; t < 20 && rfd1 !== 1'b1; t++) @(negedge clock);
    checks++; if (bank1[1] !== 8'h02) begin failures++; $display("FAIL rb_good_bank got=%h want=02", bank1[1]); end
    checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL rb_err_sticky got=%b want=1", err1); end
    checks++; if (err3 !== 1'b0) begin failures++; $display("FAIL rb_err3 got=%b want=0", err3); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (err1 !== 1'b0) begin failures++; $display("FAIL rb_err_reset got=%b want=0", err1); end
  endtask
`endif

  task automatic test_bus_discipline;
    #1;
    checks++; if (viol != 0) begin failures++; $display("FAIL bus_discipline violations=%0d want=0", viol); end
  endtask

  initial begin
    test_reset;
    test_pulse1;
    test_hold_dav;
    test_back_to_back;
    test_reset_mid;
`ifdef LATCH_BANK_WRITER_READBACK_EN
    test_readback;
`endif
    test_bus_discipline;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
